// File: rtl/bcd_digit_packer_pkg.sv
//------------------------------------------------------------------------------
// Module  : digit_pkg
// Brief   : Shared types and constants for the BCD digit packer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package digit_pkg;

  // Entry FSM: EMPTY (no digits), ENTRY (partial word), FULL (all digits held).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage : digit_pkg

`default_nettype wire

// File: rtl/bcd_digit_packer_if.sv
//------------------------------------------------------------------------------
// Module  : bcd_digit_packer_if
// Brief   : Strobe/word bundle between the keypad front-end and the packer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bcd_digit_packer_if #(
  parameter int NDIGITS = 4
);
  localparam int WORD_W = 4 * NDIGITS;
  localparam int CNT_W  = $clog2(NDIGITS + 1);

  // Front-end strobes
  logic [3:0]        digit_in;
  logic              digit_valid;
  logic              backspace;
  logic              clear;
  logic              commit;

  // Packer results
  logic [WORD_W-1:0] live_word;
  logic [CNT_W-1:0]  digit_count;
  logic              full;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              digit_err;

  // Front-end side: drives strobes, observes results.
  modport master (
    output digit_in, digit_valid, backspace, clear, commit,
    input  live_word, digit_count, full, word_out, word_valid, digit_err
  );

  // Packer side: consumes strobes, produces results.
  modport slave (
    input  digit_in, digit_valid, backspace, clear, commit,
    output live_word, digit_count, full, word_out, word_valid, digit_err
  );

endinterface : bcd_digit_packer_if

`default_nettype wire

// File: rtl/bcd_digit_packer_digit_check.sv
//------------------------------------------------------------------------------
// Module  : digit_check
// Brief   : Combinational accept/reject decision for an incoming digit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module digit_check
  import digit_pkg::*;
#(
  parameter bit BCD_ONLY = 1'b1
) (
  input  logic [DIGIT_W-1:0] i_digit,
  input  logic               i_full,
  output logic               o_accept,
  output logic               o_err
);

  logic w_is_bcd;
  logic w_bad_value;

  // A digit is rejected when the buffer has no room or, in BCD mode, it is A-F.
  always_comb begin
    w_is_bcd    = (i_digit <= BCD_MAX);
    w_bad_value = BCD_ONLY && !w_is_bcd;
    o_accept    = !i_full && !w_bad_value;
    o_err       = i_full || w_bad_value;
  end

endmodule : digit_check

`default_nettype wire

// File: rtl/bcd_digit_packer.sv
//------------------------------------------------------------------------------
// Module  : bcd_digit_packer
// Brief   : Packs keyed digits into a live display word; commit publishes it.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_digit_packer
  import digit_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter bit BCD_ONLY = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  bcd_digit_packer_if.slave bus
);

  localparam int               WORD_W   = DIGIT_W * NDIGITS;
  localparam int               CNT_W    = $clog2(NDIGITS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NDIGITS);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t            r_state,      w_state_nxt;
  logic [WORD_W-1:0] r_live,       w_live_nxt;
  logic [CNT_W-1:0]  r_count,      w_count_nxt;
  logic [WORD_W-1:0] r_word,       w_word_nxt;
  logic              r_word_valid, w_word_valid_nxt;
  logic              r_digit_err,  w_digit_err_nxt;

  logic              w_accept;
  logic              w_reject;

  digit_check #(
    .BCD_ONLY (BCD_ONLY)
  ) u_digit_check (
    .i_digit  (bus.digit_in),
    .i_full   (r_state == FULL),
    .o_accept (w_accept),
    .o_err    (w_reject)
  );

  // State register: every output is taken straight from these flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= EMPTY;
      r_live       <= '0;
      r_count      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_digit_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_live       <= w_live_nxt;
      r_count      <= w_count_nxt;
      r_word       <= w_word_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_digit_err  <= w_digit_err_nxt;
    end
  end

  // Next state: only the highest-priority strobe acts (clear > commit > backspace > digit).
  always_comb begin
    w_state_nxt      = r_state;
    w_live_nxt       = r_live;
    w_count_nxt      = r_count;
    w_word_nxt       = r_word;
    w_word_valid_nxt = 1'b0;
    w_digit_err_nxt  = 1'b0;

    if (bus.clear) begin
      w_live_nxt  = '0;
      w_count_nxt = '0;
      w_state_nxt = EMPTY;
    end else if (bus.commit) begin
      // An empty buffer has nothing to publish, so no pulse either.
      if (r_state != EMPTY) begin
        w_word_nxt       = r_live;
        w_word_valid_nxt = 1'b1;
        w_live_nxt       = '0;
        w_count_nxt      = '0;
        w_state_nxt      = EMPTY;
      end
    end else if (bus.backspace) begin
      if (r_state != EMPTY) begin
        w_live_nxt  = {{DIGIT_W{1'b0}}, r_live[WORD_W-1:DIGIT_W]};
        w_count_nxt = r_count - ONE_CNT;
        w_state_nxt = (r_count == ONE_CNT) ? EMPTY : ENTRY;
      end
    end else if (bus.digit_valid) begin
      if (w_accept) begin
        w_live_nxt  = {r_live[WORD_W-DIGIT_W-1:0], bus.digit_in};
        w_count_nxt = r_count + ONE_CNT;
        w_state_nxt = (r_count + ONE_CNT == FULL_CNT) ? FULL : ENTRY;
      end else begin
        w_digit_err_nxt = w_reject;
      end
    end
  end

  assign bus.live_word   = r_live;
  assign bus.digit_count = r_count;
  assign bus.full        = (r_state == FULL);
  assign bus.word_out    = r_word;
  assign bus.word_valid  = r_word_valid;
  assign bus.digit_err   = r_digit_err;

endmodule : bcd_digit_packer

`default_nettype wire

// File: tb/tb_bcd_digit_packer.sv
//------------------------------------------------------------------------------
// Module  : tb_bcd_digit_packer
// Brief   : Scoreboard bench for bcd_digit_packer, BCD-only and hex builds side by side.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_digit_packer;

  typedef struct {
    int live;
    int cnt;
    int full;
    int word;
    int wv;
    int err;
  } exp_t;

  logic clk;
  logic reset_n;

  int n_checks;
  int n_fail;

  // Reference state per build: index 0 = BCD-only, 1 = hex.
  int m_val  [2];
  int m_cnt  [2];
  int m_word [2];

  exp_t q0[$];
  exp_t q1[$];

  bcd_digit_packer_if #(.NDIGITS(4)) if_b ();
  bcd_digit_packer_if #(.NDIGITS(4)) if_h ();

  bcd_digit_packer #(.NDIGITS(4), .BCD_ONLY(1'b1)) u_bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  bcd_digit_packer #(.NDIGITS(4), .BCD_ONLY(1'b0)) u_hex (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i]  = 0;
      m_cnt[i]  = 0;
      m_word[i] = 0;
    end
  endtask

  // Behavioural model: the buffer is a number, digits enter as val*16+d.
  task automatic model_step(input int i, input bit bcd_only, input bit clr, input bit cmt,
                            input bit bs, input bit dv, input int d);
    exp_t e;
    e.wv  = 0;
    e.err = 0;
    if (clr) begin
      m_val[i] = 0;
      m_cnt[i] = 0;
    end else if (cmt) begin
      if (m_cnt[i] > 0) begin
        m_word[i] = m_val[i];
        e.wv      = 1;
        m_val[i]  = 0;
        m_cnt[i]  = 0;
      end
    end else if (bs) begin
      if (m_cnt[i] > 0) begin
        m_val[i] = m_val[i] / 16;
        m_cnt[i] = m_cnt[i] - 1;
      end
    end else if (dv) begin
      if (m_cnt[i] == 4 || (bcd_only && d > 9)) begin
        e.err = 1;
      end else begin
        m_val[i] = m_val[i] * 16 + d;
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
    e.live = m_val[i];
    e.cnt  = m_cnt[i];
    e.full = (m_cnt[i] == 4) ? 1 : 0;
    e.word = m_word[i];
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // One cycle of stimulus: drive on the falling edge, record what the next rising edge must produce.
  task automatic cyc(input bit clr, input bit cmt, input bit bs, input bit dv, input int d);
    @(negedge clk);
    if_b.clear = clr; if_b.commit = cmt; if_b.backspace = bs; if_b.digit_valid = dv;
    if_b.digit_in = 4'(d);
    if_h.clear = clr; if_h.commit = cmt; if_h.backspace = bs; if_h.digit_valid = dv;
    if_h.digit_in = 4'(d);
    model_step(0, 1'b1, clr, cmt, bs, dv, d);
    model_step(1, 1'b0, clr, cmt, bs, dv, d);
  endtask

  task automatic digit(input int d);
    cyc(0, 0, 0, 1, d);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic idle_inputs();
    if_b.clear = 0; if_b.commit = 0; if_b.backspace = 0; if_b.digit_valid = 0; if_b.digit_in = 0;
    if_h.clear = 0; if_h.commit = 0; if_h.backspace = 0; if_h.digit_valid = 0; if_h.digit_in = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bcd_live"},  int'(if_b.live_word),   0);
    chk({tag, "_bcd_cnt"},   int'(if_b.digit_count), 0);
    chk({tag, "_bcd_full"},  int'(if_b.full),        0);
    chk({tag, "_bcd_word"},  int'(if_b.word_out),    0);
    chk({tag, "_bcd_wv"},    int'(if_b.word_valid),  0);
    chk({tag, "_bcd_err"},   int'(if_b.digit_err),   0);
    chk({tag, "_hex_live"},  int'(if_h.live_word),   0);
    chk({tag, "_hex_word"},  int'(if_h.word_out),    0);
  endtask

  // Monitor: after every rising edge, pop the pending expectation of each build and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("bcd_live", int'(if_b.live_word),   e.live);
        chk("bcd_cnt",  int'(if_b.digit_count), e.cnt);
        chk("bcd_full", int'(if_b.full),        e.full);
        chk("bcd_word", int'(if_b.word_out),    e.word);
        chk("bcd_wv",   int'(if_b.word_valid),  e.wv);
        chk("bcd_err",  int'(if_b.digit_err),   e.err);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("hex_live", int'(if_h.live_word),   e.live);
        chk("hex_cnt",  int'(if_h.digit_count), e.cnt);
        chk("hex_full", int'(if_h.full),        e.full);
        chk("hex_word", int'(if_h.word_out),    e.word);
        chk("hex_wv",   int'(if_h.word_valid),  e.wv);
        chk("hex_err",  int'(if_h.digit_err),   e.err);
      end
    end
  end

  initial begin
    int r;
    int budget;
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    idle_inputs();
    reset_n = 1'b0;
    #13;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Fill to four digits, then publish.
    digit(1); digit(2); digit(3); digit(4);
    cyc(0, 1, 0, 0, 0);
    idle();

    // Overflow attempt in FULL, then backspace out of FULL.
    digit(1); digit(2); digit(3); digit(4);
    digit(5);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // Hex digit B: rejected by the BCD build, accepted by the hex build.
    digit(11);
    cyc(1, 0, 0, 0, 0);

    // Commit beats a same-cycle digit; clear beats a same-cycle commit.
    digit(4); digit(2);
    cyc(0, 1, 0, 1, 7);
    digit(5);
    cyc(1, 1, 0, 0, 0);

    // Commit and backspace with nothing entered.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle();

    // Asynchronous reset in the middle of an entry.
    digit(9); digit(8);
    @(negedge clk);
    idle_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    digit(3);
    idle();

    // Randomized strobe mix.
    for (int n = 0; n < 3000; n++) begin
      bit clr, cmt, bs, dv;
      r   = $urandom_range(0, 99);
      clr = (r < 4);
      cmt = ($urandom_range(0, 99) < 10);
      bs  = ($urandom_range(0, 99) < 15);
      dv  = ($urandom_range(0, 99) < 70);
      cyc(clr, cmt, bs, dv, $urandom_range(0, 15));
    end

    @(negedge clk);
    idle_inputs();
    budget = 0;
    while ((q0.size() > 0 || q1.size() > 0) && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    chk("scoreboard_drained", q0.size() + q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bcd_digit_packer

`default_nettype wire

// File: doc/bcd_digit_packer.md
# bcd_digit_packer

Sequential digit-entry assembler: accepts one 4-bit digit per valid strobe from keypad/switch front-end logic and packs digits, most recent in the least significant nibble, into a 16-bit word. The live buffer drives the display multiplexer's 16-bit input directly, so the 7-segment display shows digits as they are typed. A commit strobe latches the buffer into a held output word, emits a one-cycle valid pulse, and empties the buffer for the next entry.

## Interface
Parameters:
- NDIGITS, 4, digits per word; word width is 4*NDIGITS.
- BCD_ONLY, 1, when 1 digits 4'hA–4'hF are rejected; when 0 all hex digits are accepted.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- digit_in  in  4  digit value, sampled when digit_valid=1.
- digit_valid  in  1  one-cycle strobe: append digit_in.
- backspace  in  1  one-cycle strobe: remove most recent digit.
- clear  in  1  one-cycle strobe: empty buffer.
- commit  in  1  one-cycle strobe: publish buffer.
- live_word  out  16  current entry buffer, for display.
- digit_count  out  3  digits held, 0..NDIGITS.
- full  out  1  digit_count == NDIGITS.
- word_out  out  16  last committed word, held until next commit.
- word_valid  out  1  one-cycle pulse when word_out updates.
- digit_err  out  1  one-cycle pulse: digit rejected (invalid BCD or buffer full).

## Operation
- FSM states: EMPTY (count 0), ENTRY (1..NDIGITS-1), FULL (NDIGITS). State is derived-consistent with digit_count at all times.
- Strobe priority when several are high in one cycle: clear > commit > backspace > digit_valid; lower-priority strobes that cycle are dropped, with no error pulse.
- digit_valid, accepted: live_word <= {live_word[11:0], digit_in}; count+1. EMPTY→ENTRY; ENTRY→FULL on reaching NDIGITS.
- digit_valid in FULL: ignored, buffer unchanged, digit_err pulses.
- digit_valid with BCD_ONLY=1 and digit_in>9: ignored, digit_err pulses, in any state.
- backspace: live_word <= {4'h0, live_word[15:4]}; count-1. FULL→ENTRY; ENTRY→EMPTY at count 0. In EMPTY it is ignored and raises no error.
- clear: live_word <= 0, count <= 0, →EMPTY from any state. word_out is unaffected.
- commit in ENTRY/FULL: word_out <= live_word; word_valid pulses; live_word <= 0; count <= 0; →EMPTY. Commit in EMPTY is ignored, with no pulse.
- Leading unentered nibbles are always 0.

## Timing
- All outputs are registered. Effects of a strobe sampled at edge N are visible after edge N; pulses are high for exactly the cycle following edge N.
- Back-to-back strobes on consecutive cycles are each processed; there is no busy period.
- Commit latency is 1 cycle. live_word reads 0 in the same cycle that word_valid is high.
- Reset, asynchronous assert at any time, including mid-entry: live_word=0, digit_count=0, full=0, word_out=0, word_valid=0, digit_err=0, state EMPTY. Reset release is synchronized externally; the first strobe is honoured on the first edge after deassertion.
- Strobes held high for more than one cycle act once per cycle. Edge detection is the front-end's job.

## Structure
- Shared package digit_pkg: state enum {EMPTY, ENTRY, FULL}, DIGIT_W=4, BCD_MAX=4'd9.
- One combinational sub-module, digit_check, is natural: inputs digit_in, BCD_ONLY, full; outputs accept/err. Everything else lives in one always_ff plus next-state always_comb.

## Test plan
- Reset, then digits 1,2,3,4 on consecutive cycles -> live_word 16'h0001, 0012, 0123, 1234; full=1 after the 4th; commit -> word_out=16'h1234, word_valid high for 1 cycle, live_word=0, count=0.
- FULL at 16'h1234, digit 5 -> digit_err pulse, live_word stays 16'h1234; backspace -> 16'h0123, count=3, full=0.
- BCD_ONLY=1, digit 4'hB in EMPTY -> digit_err pulse, count stays 0. Same stimulus with BCD_ONLY=0 -> live_word=16'h000B, no error.
- Same cycle: commit+digit 7 with buffer 16'h0042 -> word_out=16'h0042, live_word=0 (digit dropped). Same cycle: clear+commit -> buffer 0, word_out unchanged, no word_valid.
- Commit in EMPTY -> no word_valid, word_out holds its previous value. Backspace in EMPTY -> no change, no error.
- Enter 9,8, then assert reset_n=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge; after release, digit 3 -> live_word=16'h0003.
